// File: rtl/cpu5_alu_arb_pkg.sv
// rtl/cpu5_alu_arb_pkg.sv - shared constants and types for the two-port ALU arbiter
package cpu5_alu_arb_pkg;

  localparam int CPU5_ALU_CONTROL_SIZE   = 3;
  localparam int CPU5_ALU_ARB_STATE_SIZE = 2;

  localparam logic [CPU5_ALU_ARB_STATE_SIZE-1:0] CPU5_ALU_ARB_IDLE = 2'd0;
  localparam logic [CPU5_ALU_ARB_STATE_SIZE-1:0] CPU5_ALU_ARB_EXEC = 2'd1;
  localparam logic [CPU5_ALU_ARB_STATE_SIZE-1:0] CPU5_ALU_ARB_RESP = 2'd2;

  localparam logic [CPU5_ALU_CONTROL_SIZE-1:0] ALU_CTRL_ADD = 3'b010;
  localparam logic [CPU5_ALU_CONTROL_SIZE-1:0] ALU_CTRL_SUB = 3'b110;

  typedef enum logic {
    PORT0 = 1'b0,
    PORT1 = 1'b1
  } port_t;

  function automatic port_t gnt_to_port(input logic [1:0] gnt);
    return gnt[1] ? PORT1 : PORT0;
  endfunction

endpackage

// File: rtl/cpu5_alu_arb_if.sv
// rtl/cpu5_alu_arb_if.sv - requester/response handshakes and shared ALU bus
interface cpu5_alu_arb_if
  import cpu5_alu_arb_pkg::*;
#(
  parameter int XLEN   = 32,
  parameter int CTRL_W = CPU5_ALU_CONTROL_SIZE
) ();

  logic              req0_valid;
  logic              req0_ready;
  logic [XLEN-1:0]   req0_a;
  logic [XLEN-1:0]   req0_b;
  logic [CTRL_W-1:0] req0_ctrl;

  logic              req1_valid;
  logic              req1_ready;
  logic [XLEN-1:0]   req1_a;
  logic [XLEN-1:0]   req1_b;
  logic [CTRL_W-1:0] req1_ctrl;

  logic              rsp0_valid;
  logic              rsp0_ready;
  logic              rsp1_valid;
  logic              rsp1_ready;
  logic [XLEN-1:0]   rsp_result;
  logic              rsp_zero;

  logic [XLEN-1:0]   alu_a;
  logic [XLEN-1:0]   alu_b;
  logic [CTRL_W-1:0] alu_control;
  logic [XLEN-1:0]   alu_result;

  modport slave (
    input  req0_valid, req0_a, req0_b, req0_ctrl,
    input  req1_valid, req1_a, req1_b, req1_ctrl,
    output req0_ready, req1_ready,
    output rsp0_valid, rsp1_valid, rsp_result, rsp_zero,
    input  rsp0_ready, rsp1_ready,
    output alu_a, alu_b, alu_control,
    input  alu_result
  );

  modport master (
    output req0_valid, req0_a, req0_b, req0_ctrl,
    output req1_valid, req1_a, req1_b, req1_ctrl,
    input  req0_ready, req1_ready,
    input  rsp0_valid, rsp1_valid, rsp_result, rsp_zero,
    output rsp0_ready, rsp1_ready,
    input  alu_a, alu_b, alu_control,
    output alu_result
  );

endinterface

// File: rtl/cpu5_alu_arb_rr_arb2.sv
// rtl/cpu5_alu_arb_rr_arb2.sv - combinational two-way round-robin picker
module cpu5_rr_arb2 (
  input  logic [1:0] req,
  input  logic       last,
  output logic [1:0] gnt
);

  // On a tie the port that did not win last time is chosen.
  assign gnt[0] = req[0] & (~req[1] | last);
  assign gnt[1] = req[1] & (~req[0] | ~last);

endmodule

// File: rtl/cpu5_alu_arb.sv
// rtl/cpu5_alu_arb.sv - shares one combinational ALU between execute and address-gen ports
module cpu5_alu_arb
  import cpu5_alu_arb_pkg::*;
#(
  parameter int XLEN   = 32,
  parameter int CTRL_W = CPU5_ALU_CONTROL_SIZE
) (
  input logic             clk,
  input logic             reset,
  cpu5_alu_arb_if.slave   bus
);

  logic [CPU5_ALU_ARB_STATE_SIZE-1:0] state;
  port_t                              last_grant;
  port_t                              grant_id;

  logic [1:0]        req;
  logic [1:0]        gnt;
  logic              idle;
  logic              accept;
  logic              rsp_ready_sel;

  logic [XLEN-1:0]   sel_a;
  logic [XLEN-1:0]   sel_b;
  logic [CTRL_W-1:0] sel_ctrl;

  logic [XLEN-1:0]   a_q;
  logic [XLEN-1:0]   b_q;
  logic [CTRL_W-1:0] ctrl_q;
  logic [XLEN-1:0]   result_q;
  logic              zero_q;

  assign req = {bus.req1_valid, bus.req0_valid};

  cpu5_rr_arb2 u_rr_arb2 (
    .req  (req),
    .last (last_grant == PORT1),
    .gnt  (gnt)
  );

  // Ready is masked while reset is held so a requester holding valid sees no accept.
  assign idle   = (state == CPU5_ALU_ARB_IDLE) && !reset;
  assign accept = idle && (gnt != 2'b00);

  assign bus.req0_ready = idle & gnt[0];
  assign bus.req1_ready = idle & gnt[1];

  assign sel_a    = gnt[1] ? bus.req1_a    : bus.req0_a;
  assign sel_b    = gnt[1] ? bus.req1_b    : bus.req0_b;
  assign sel_ctrl = gnt[1] ? bus.req1_ctrl : bus.req0_ctrl;

  assign bus.rsp0_valid = (state == CPU5_ALU_ARB_RESP) && (grant_id == PORT0);
  assign bus.rsp1_valid = (state == CPU5_ALU_ARB_RESP) && (grant_id == PORT1);
  assign rsp_ready_sel  = (grant_id == PORT1) ? bus.rsp1_ready : bus.rsp0_ready;

  assign bus.rsp_result  = result_q;
  assign bus.rsp_zero    = zero_q;
  assign bus.alu_a       = a_q;
  assign bus.alu_b       = b_q;
  assign bus.alu_control = ctrl_q;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state      <= CPU5_ALU_ARB_IDLE;
      last_grant <= PORT1;
      grant_id   <= PORT0;
      a_q        <= '0;
      b_q        <= '0;
      ctrl_q     <= '0;
      result_q   <= '0;
      zero_q     <= 1'b1;
    end else begin
      case (state)
        CPU5_ALU_ARB_IDLE: begin
          if (accept) begin
            a_q        <= sel_a;
            b_q        <= sel_b;
            ctrl_q     <= sel_ctrl;
            grant_id   <= gnt_to_port(gnt);
            last_grant <= gnt_to_port(gnt);
            state      <= CPU5_ALU_ARB_EXEC;
          end
        end
        CPU5_ALU_ARB_EXEC: begin
          result_q <= bus.alu_result;
          zero_q   <= ~|bus.alu_result;
          state    <= CPU5_ALU_ARB_RESP;
        end
        CPU5_ALU_ARB_RESP: begin
          if (rsp_ready_sel) begin
            state <= CPU5_ALU_ARB_IDLE;
          end
        end
        default: state <= CPU5_ALU_ARB_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_cpu5_alu_arb.sv
// tb/tb_cpu5_alu_arb.sv - directed self-checking bench for cpu5_alu_arb
module tb_cpu5_alu_arb;
  import cpu5_alu_arb_pkg::*;

  logic clk = 1'b0;
  logic reset;
  int   cyc = 0;
  int   vectors = 0;
  int   miscompares = 0;

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  cpu5_alu_arb_if bus ();

  cpu5_alu_arb dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  always_comb begin
    if (bus.alu_control == ALU_CTRL_SUB) bus.alu_result = bus.alu_a - bus.alu_b;
    else                                 bus.alu_result = bus.alu_a + bus.alu_b;
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  logic [31:0] sa, sb, sexp;
  logic [2:0]  sctrl;
  int          exp_port;
  int          t0;

  initial begin
    reset = 1'b1;
    bus.req0_valid = 0; bus.req0_a = 0; bus.req0_b = 0; bus.req0_ctrl = 0;
    bus.req1_valid = 0; bus.req1_a = 0; bus.req1_b = 0; bus.req1_ctrl = 0;
    bus.rsp0_ready = 0; bus.rsp1_ready = 0;
    repeat (2) tick();

    bus.req0_valid = 1; #1;
    chk("rst_req0_ready", bus.req0_ready, 0);
    chk("rst_rsp0_valid", bus.rsp0_valid, 0);
    chk("rst_rsp1_valid", bus.rsp1_valid, 0);
    chk("rst_rsp_result", bus.rsp_result, 0);
    chk("rst_rsp_zero", bus.rsp_zero, 1);
    chk("rst_alu_a", bus.alu_a, 0);
    chk("rst_alu_b", bus.alu_b, 0);
    chk("rst_alu_ctrl", bus.alu_control, 0);
    bus.req0_valid = 0;
    reset = 1'b0;
    tick();

    // single op on port 0
    bus.req0_valid = 1; bus.req0_a = 5; bus.req0_b = 7; bus.req0_ctrl = ALU_CTRL_ADD; #1;
    chk("op1_req0_ready", bus.req0_ready, 1);
    chk("op1_req1_ready", bus.req1_ready, 0);
    tick();
    bus.req0_valid = 0; #1;
    chk("op1_alu_a", bus.alu_a, 5);
    chk("op1_alu_b", bus.alu_b, 7);
    chk("op1_alu_ctrl", bus.alu_control, 3'b010);
    chk("op1_exec_rsp0_valid", bus.rsp0_valid, 0);
    tick();
    chk("op1_rsp0_valid", bus.rsp0_valid, 1);
    chk("op1_rsp_result", bus.rsp_result, 12);
    chk("op1_rsp_zero", bus.rsp_zero, 0);
    chk("op1_rsp1_valid", bus.rsp1_valid, 0);
    bus.rsp0_ready = 1;
    tick();
    bus.rsp0_ready = 0; #1;
    chk("op1_done_rsp0_valid", bus.rsp0_valid, 0);

    // reset asserted during EXEC
    bus.req1_valid = 1; bus.req1_a = 100; bus.req1_b = 1; bus.req1_ctrl = ALU_CTRL_ADD; #1;
    chk("rm_req1_ready", bus.req1_ready, 1);
    tick();
    chk("rm_exec_alu_a", bus.alu_a, 100);
    reset = 1'b1; #1;
    chk("rm_req1_ready_rst", bus.req1_ready, 0);
    chk("rm_rsp1_valid", bus.rsp1_valid, 0);
    chk("rm_rsp_result", bus.rsp_result, 0);
    chk("rm_rsp_zero", bus.rsp_zero, 1);
    chk("rm_alu_a", bus.alu_a, 0);
    tick();
    reset = 1'b0;

    // continuous ties alternate 0,1,0,1
    bus.req0_valid = 1; bus.req0_a = 9; bus.req0_b = 9; bus.req0_ctrl = ALU_CTRL_SUB;
    bus.req1_valid = 1; bus.req1_a = 1; bus.req1_b = 2; bus.req1_ctrl = ALU_CTRL_ADD;
    for (int r = 0; r < 4; r++) begin
      exp_port = r % 2;
      #1;
      chk("tie_rdy0", bus.req0_ready, exp_port == 0);
      chk("tie_rdy1", bus.req1_ready, exp_port == 1);
      tick();
      tick();
      chk("tie_rsp0_valid", bus.rsp0_valid, exp_port == 0);
      chk("tie_rsp1_valid", bus.rsp1_valid, exp_port == 1);
      chk("tie_result", bus.rsp_result, (exp_port == 0) ? 0 : 3);
      chk("tie_zero", bus.rsp_zero, exp_port == 0);
      if (exp_port == 0) bus.rsp0_ready = 1;
      else               bus.rsp1_ready = 1;
      tick();
      bus.rsp0_ready = 0; bus.rsp1_ready = 0;
    end

    // response backpressure on port 0 with port 1 waiting
    bus.req0_a = 20; bus.req0_b = 22; bus.req0_ctrl = ALU_CTRL_ADD;
    bus.req1_a = 7;  bus.req1_b = 3;  bus.req1_ctrl = ALU_CTRL_SUB; #1;
    chk("bp_rdy0", bus.req0_ready, 1);
    chk("bp_rdy1", bus.req1_ready, 0);
    tick();
    tick();
    bus.rsp1_ready = 1;
    repeat (5) begin
      #1;
      chk("bp_rsp0_valid", bus.rsp0_valid, 1);
      chk("bp_rsp_result", bus.rsp_result, 42);
      chk("bp_req1_ready", bus.req1_ready, 0);
      chk("bp_rsp1_valid", bus.rsp1_valid, 0);
      tick();
    end
    bus.rsp0_ready = 1; bus.rsp1_ready = 0;
    tick();
    bus.rsp0_ready = 0; bus.req0_valid = 0; #1;
    chk("bp_req1_accept", bus.req1_ready, 1);
    tick();
    tick();
    chk("bp_rsp1_valid_after", bus.rsp1_valid, 1);
    chk("bp_rsp1_result", bus.rsp_result, 4);
    bus.rsp1_ready = 1;
    tick();

    // back-to-back stream on port 1
    t0 = cyc;
    for (int i = 0; i < 10; i++) begin
      sa    = 32'(1000 * i + 17);
      sb    = 32'(3 * i + 1);
      sctrl = (i % 2 == 1) ? ALU_CTRL_SUB : ALU_CTRL_ADD;
      sexp  = (sctrl == ALU_CTRL_SUB) ? sa - sb : sa + sb;
      bus.req1_a = sa; bus.req1_b = sb; bus.req1_ctrl = sctrl; #1;
      chk("st_req1_ready", bus.req1_ready, 1);
      tick();
      tick();
      if (i == 3) begin
        bus.req0_valid = 1; #1;
        chk("st_req0_pulse_ready", bus.req0_ready, 0);
        bus.req0_valid = 0;
      end
      chk("st_rsp1_valid", bus.rsp1_valid, 1);
      chk("st_rsp0_valid", bus.rsp0_valid, 0);
      chk("st_alu_a", bus.alu_a, sa);
      chk("st_result", bus.rsp_result, sexp);
      tick();
    end
    chk("st_cycles", cyc - t0, 30);
    chk("st_end_rsp1_valid", bus.rsp1_valid, 0);
    chk("st_end_req1_ready", bus.req1_ready, 1);

    bus.req1_valid = 0; bus.rsp1_ready = 0;
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule

// File: doc/cpu5_alu_arb.md
Name: cpu5_alu_arb

Overview:
- Shares the single combinational ALU between two requesters: port 0 is the execute stage, port 1 is the load/store address generator.
- Accepts one operation at a time through a valid/ready handshake and drives the captured operands and control onto the ALU.
- Registers the ALU result and returns it to the granted requester with its own valid/ready handshake.
- Two-way round-robin arbitration prevents either requester from starving the other.

Parameters:
- XLEN, 32, operand and result width.
- CTRL_W, `CPU5_ALU_CONTROL_SIZE (3), ALU control width.

Ports:
- clk  in  1  clock, rising edge.
- reset  in  1  asynchronous, active-high reset.
- req0_valid / req1_valid  in  1  requester n has an operation.
- req0_ready / req1_ready  out  1  operation accepted this cycle.
- req0_a, req0_b / req1_a, req1_b  in  XLEN  operands.
- req0_ctrl / req1_ctrl  in  CTRL_W  ALU control code (3'b010 add, 3'b110 sub).
- rsp0_valid / rsp1_valid  out  1  result valid for requester n.
- rsp0_ready / rsp1_ready  in  1  requester n consumes the result.
- rsp_result  out  XLEN  registered result, shared by both ports.
- rsp_zero  out  1  result == 0.
- alu_a, alu_b  out  XLEN  to shared ALU.
- alu_control  out  CTRL_W  to shared ALU.
- alu_result  in  XLEN  from shared ALU, combinational.

Behaviour:
- Reset values:
  - state=IDLE, last_grant=1, so port 0 wins the first tie.
  - All ready and valid outputs 0.
  - rsp_result=0, rsp_zero=1.
  - alu_a=0, alu_b=0, alu_control=0; the operand and control registers are cleared.
- States: IDLE, EXEC, RESP. Encodings are 2 bits.
- IDLE:
  - reqN_ready=1 only for the arbiter winner, and only when that port's valid is high. The other ready is 0.
  - Single requester: that requester wins.
  - Both requesting: the port != last_grant wins.
  - On accept: capture a, b, ctrl and grant id; set last_grant=grant id; go to EXEC.
  - Ready is a function of valid. Requesters must not make valid depend on ready.
- EXEC:
  - alu_a, alu_b and alu_control are driven from the captured registers (they are registered outputs, stable throughout EXEC).
  - At the end of the cycle, rsp_result<=alu_result and rsp_zero<=(alu_result==0); go to RESP.
  - No requester is ready.
- RESP:
  - rsp{grant}_valid=1; the other rsp valid stays 0.
  - rsp_result holds until rsp{grant}_ready=1, then go to IDLE.
  - No new acceptance happens in RESP, including the handshake cycle.
- Latency: accept at edge N, so rsp_valid is high during cycle N+1..; the earliest consume is at edge N+2. Peak throughput is 1 operation per 3 cycles.
- Operands are held in alu_* after EXEC. This is a don't-care for the ALU; the outputs change only on accept.
- A requester that drops valid without a handshake simply loses arbitration; no state is affected.
- reqN_valid during EXEC/RESP is ignored and not accepted; the requester must hold it.
- rsp ready asserted outside RESP, or on the non-granted port, is ignored.
- Reset mid-operation: asynchronous return to IDLE, and the pending result is discarded.
- Width: no arithmetic in the block; rsp_zero is the XLEN-wide NOR of the result.

Decomposition:
- defines.v gains:
  - `CPU5_ALU_ARB_STATE_SIZE (2).
  - `CPU5_ALU_ARB_IDLE, `CPU5_ALU_ARB_EXEC, `CPU5_ALU_ARB_RESP.
  - Reuse of `CPU5_ALU_CONTROL_SIZE.
- Sub-module cpu5_rr_arb2:
  - Combinational 2-way round-robin picker.
  - Inputs: req[1:0], last.
  - Outputs: gnt[1:0] (one-hot or zero).
  - Reusable for other shared units.

Test Plan:
- Single op: req0 valid, a=5, b=7, ctrl=3'b010; ALU model adds.
  - req0_ready=1 in the accept cycle.
  - alu_a=5, alu_b=7, alu_control=010 in EXEC.
  - rsp0_valid=1 with rsp_result=12 and rsp_zero=0 two cycles after accept; rsp1_valid stays 0.
- Tie after reset: both valid (req0 a=9,b=9,sub; req1 a=1,b=2,add).
  - Port 0 wins first: rsp0 result 0, rsp_zero=1.
  - Port 1 wins next: rsp1 result 3.
  - Continuous ties alternate 0,1,0,1.
- Response backpressure: hold rsp0_ready=0 for 5 cycles.
  - rsp0_valid and rsp_result stay stable.
  - req1_valid is high but req1_ready stays 0 throughout.
  - One cycle after rsp0_ready=1, IDLE accepts req1.
- Reset mid-op: assert reset in EXEC.
  - Immediately all valid/ready=0 and rsp_result=0.
  - After release, the first tie grants port 0.
- Ignored signals:
  - rsp1_ready=1 while rsp0 is pending has no effect.
  - req0_valid pulsed during RESP is not accepted.
  - Max-throughput stream of 10 ops on port 1 completes in 30 cycles, with results matching the model.
